fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 204 ++++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pulls words from a FIFO read port in bursts of BURST_LEN
// and presents them on a valid/ready stream with a last-beat marker.
// A small 4-entry skid buffer decouples FIFO read latency from stream
// back-pressure.
module fifo_burst_reader #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic              r_clk,
  input  logic              rrst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              rd_req,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_rd
);

  localparam int BCW = $clog2(BURST_LEN);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;

  state_t            r_state;
  state_t            w_next_state;

  logic [BCW-1:0]    r_rd_cnt;
  logic [BCW-1:0]    r_out_cnt;
  logic              r_inflight;
  logic [2:0]        r_buf_cnt;
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [DATA_W-1:0] r_buf [4];
  logic [CNT_W-1:0]  r_words_rd;

  logic              w_push;
  logic              w_pop;
  logic              w_room;
  logic              w_burst_end;

  // Reset asserts immediately but is released only after two r_clk edges,
  // so every flop below leaves reset on the same clean edge.
  always_ff @(posedge r_clk or negedge rrst) begin
    if (!rrst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Buffer bookkeeping: a word lands one cycle after its read request, and
  // a word leaves on a stream handshake; both may happen together.
  assign w_push = r_inflight;
  assign w_pop  = m_valid & m_ready;

  // Issuing only while buffered plus in-flight words are at most two keeps
  // the buffer at three entries or fewer, yet still allows one read per
  // cycle when the consumer drains one beat per cycle.
  assign w_room = ((r_buf_cnt + {2'b00, r_inflight}) <= 3'd2);

  // A burst boundary is either an idle boundary (no read pending in the
  // current burst) or the read that completes the current burst.
  assign w_burst_end = (!rd_req && (r_rd_cnt == '0)) ||
                       (rd_req && (r_rd_cnt == LAST_IDX));

  // FSM state register.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: enable is only honoured at burst boundaries, so a burst
  // that has started always completes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (!enable && w_burst_end) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_buf_cnt == 3'd0) && !r_inflight) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM outputs: read requests only in RUN with data available and room.
  always_comb begin
    rd_req = 1'b0;
    busy   = 1'b0;
    if (r_state == RUN) begin
      rd_req = !fifo_empty && w_room;
    end
    if (r_state != IDLE) begin
      busy = 1'b1;
    end
  end

  // Remember that a read was issued so its data is captured next cycle.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rd_req;
    end
  end

  // Position within the current burst on the read side.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd_cnt <= '0;
    end else if (rd_req) begin
      if (r_rd_cnt == LAST_IDX) begin
        r_rd_cnt <= '0;
      end else begin
        r_rd_cnt <= r_rd_cnt + BCW'(1);
      end
    end
  end

  // Buffer storage; contents are meaningless while the entry is not counted.
  always_ff @(posedge r_clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= data_out;
    end
  end

  // Buffer pointers and occupancy; reset discards anything held or in flight.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_buf_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_buf_cnt <= r_buf_cnt + 3'd1;
        2'b01:   r_buf_cnt <= r_buf_cnt - 3'd1;
        default: r_buf_cnt <= r_buf_cnt;
      endcase
    end
  end

  // Position within the current burst on the stream side, for m_last.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_cnt <= '0;
    end else if (w_pop) begin
      if (r_out_cnt == LAST_IDX) begin
        r_out_cnt <= '0;
      end else begin
        r_out_cnt <= r_out_cnt + BCW'(1);
      end
    end
  end

  // Running count of delivered beats, held at all-ones once it saturates.
  always_ff @(posedge r_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_words_rd <= '0;
    end else if (w_pop && (r_words_rd != {CNT_W{1'b1}})) begin
      r_words_rd <= r_words_rd + CNT_W'(1);
    end
  end

  assign m_valid  = (r_buf_cnt != 3'd0);
  assign m_data   = r_buf[r_rd_ptr];
  assign m_last   = m_valid && (r_out_cnt == LAST_IDX);
  assign words_rd = r_words_rd;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scenarios against a FIFO model; a monitor
// compares every presented beat against a queue of expected beats.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          r_clk      = 1'b0;
  logic          rrst       = 1'b0;
  logic          enable     = 1'b0;
  logic          m_ready    = 1'b0;
  logic          fifo_empty;
  logic          rd_req;
  logic [DW-1:0] data_out   = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic [CW-1:0] words_rd;

  logic [31:0]   fifoMem [0:127];
  int            fifoWr    = 0;
  int            fifoRd    = 0;
  logic          flushReq  = 1'b0;

  beat_t         expQ [$];
  int            testsRun  = 0;
  int            failCount = 0;
  int            stopReads = 0;
  int            readBase  = 0;

  fifo_burst_reader #(
    .DATA_W    (DW),
    .BURST_LEN (BL),
    .CNT_W     (CW)
  ) dut (
    .r_clk      (r_clk),
    .rrst       (rrst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .rd_req     (rd_req),
    .data_out   (data_out),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .words_rd   (words_rd)
  );

  // Free-running clock.
  always #5 r_clk = ~r_clk;

  assign fifo_empty = (fifoRd >= fifoWr);

  // FIFO read side: data appears the cycle after a read request.
  always @(posedge r_clk) begin
    if (flushReq) begin
      fifoRd <= fifoWr;
    end else if (rd_req) begin
      data_out <= fifoMem[fifoRd[6:0]];
      fifoRd   <= fifoRd + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: samples late in the cycle, after stimulus has settled.
  always @(negedge r_clk) begin
    #3;
    if (rrst && m_valid) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected beat: got 0x%0h, expected no beat", m_data);
      end else begin
        checkOutput("beat data", m_data, expQ[0].data);
        checkOutput("beat last", 32'(m_last), 32'(expQ[0].last));
        if (m_ready) begin
          void'(expQ.pop_front());
        end
      end
    end
  end

  // Load FIFO words and queue the beats expected to come out of them.
  task automatic applyStimulus(input logic [31:0] firstWord, input int nWords,
                               input int nExpect, input int startBeat);
    beat_t b;
    for (int i = 0; i < nWords; i++) begin
      fifoMem[fifoWr[6:0]] = firstWord + 32'(i);
      fifoWr++;
      if (i < nExpect) begin
        b.data = firstWord + 32'(i);
        b.last = (((startBeat + i) % BL) == BL - 1);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic tick();
    @(negedge r_clk);
    if (stopReads > 0 && (fifoRd - readBase) >= stopReads) begin
      enable = 1'b0;
    end
  endtask

  task automatic flushFifo();
    flushReq = 1'b1;
    @(posedge r_clk);
    #1;
    flushReq = 1'b0;
  endtask

  task automatic doReset();
    rrst      = 1'b0;
    enable    = 1'b0;
    m_ready   = 1'b0;
    stopReads = 0;
    repeat (2) tick();
    flushFifo();
    expQ.delete();
    rrst = 1'b1;
    repeat (3) tick();
    readBase = fifoRd;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < 300);
    checkOutput({name, " idle"}, 32'(busy), 32'd0);
  endtask

  // Safety net against a hung design.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstReq;
    int firstValid;
    int t;
    int hs;

    // Reset held with active-looking inputs.
    applyStimulus(32'hDEAD0000, 4, 0, 0);
    enable  = 1'b1;
    m_ready = 1'b1;
    repeat (4) tick();
    checkOutput("reset rd_req",   32'(rd_req),   32'd0);
    checkOutput("reset m_valid",  32'(m_valid),  32'd0);
    checkOutput("reset m_last",   32'(m_last),   32'd0);
    checkOutput("reset busy",     32'(busy),     32'd0);
    checkOutput("reset words_rd", 32'(words_rd), 32'd0);
    doReset();

    // Two back-to-back bursts at full rate.
    applyStimulus(32'h1, 8, 8, 0);
    stopReads = 5;
    m_ready   = 1'b1;
    enable    = 1'b1;
    firstReq   = -1;
    firstValid = -1;
    t = 0;
    while (firstValid < 0 && t < 50) begin
      tick();
      if (rd_req && firstReq < 0) firstReq = t;
      if (m_valid) firstValid = t;
      t++;
    end
    checkOutput("first valid latency", 32'(firstValid - firstReq), 32'd2);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("stream gap", 32'(m_valid), 32'd1);
    end
    waitIdle("burst8");
    checkOutput("words_rd after 8", 32'(words_rd), 32'd8);
    checkOutput("beats left burst8", 32'(expQ.size()), 32'd0);
    doReset();

    // Consumer stalls for 6 cycles mid-stream.
    applyStimulus(32'h101, 12, 12, 0);
    stopReads = 9;
    m_ready   = 1'b1;
    enable    = 1'b1;
    hs = 0;
    t  = 0;
    while (hs < 3 && t < 50) begin
      tick();
      if (m_valid && m_ready) hs++;
      t++;
    end
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 1) checkOutput("stall rd_req", 32'(rd_req), 32'd0);
    end
    checkOutput("reads during stall", 32'(fifoRd - readBase), 32'd5);
    m_ready = 1'b1;
    waitIdle("stall");
    checkOutput("words_rd after stall", 32'(words_rd), 32'd12);
    checkOutput("beats left stall", 32'(expQ.size()), 32'd0);
    doReset();

    // FIFO runs dry after beat 2, refilled 5 cycles later.
    applyStimulus(32'h201, 2, 2, 0);
    stopReads = 1;
    m_ready   = 1'b1;
    enable    = 1'b1;
    hs = 0;
    t  = 0;
    while (hs < 2 && t < 50) begin
      tick();
      if (m_valid && m_ready) hs++;
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("empty busy",    32'(busy),    32'd1);
      checkOutput("empty m_valid", 32'(m_valid), 32'd0);
    end
    applyStimulus(32'h203, 2, 2, 2);
    waitIdle("empty");
    checkOutput("words_rd after empty", 32'(words_rd), 32'd4);
    checkOutput("beats left empty", 32'(expQ.size()), 32'd0);
    doReset();

    // Enable dropped after the first beat: burst still completes.
    applyStimulus(32'h301, 8, 4, 0);
    m_ready = 1'b1;
    enable  = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!(m_valid && m_ready) && t < 50);
    enable = 1'b0;
    waitIdle("drop");
    checkOutput("drop read count", 32'(fifoRd - readBase), 32'd4);
    checkOutput("words_rd after drop", 32'(words_rd), 32'd4);
    checkOutput("beats left drop", 32'(expQ.size()), 32'd0);
    doReset();

    // Reset mid-burst with two words buffered.
    applyStimulus(32'hA1, 2, 2, 0);
    m_ready = 1'b0;
    enable  = 1'b1;
    repeat (6) tick();
    rrst = 1'b0;
    #1;
    checkOutput("midreset rd_req",   32'(rd_req),   32'd0);
    checkOutput("midreset m_valid",  32'(m_valid),  32'd0);
    checkOutput("midreset m_last",   32'(m_last),   32'd0);
    checkOutput("midreset busy",     32'(busy),     32'd0);
    checkOutput("midreset words_rd", 32'(words_rd), 32'd0);
    expQ.delete();
    enable = 1'b0;
    repeat (2) tick();
    rrst = 1'b1;
    repeat (3) tick();
    readBase = fifoRd;
    applyStimulus(32'hB1, 4, 4, 0);
    stopReads = 1;
    m_ready   = 1'b1;
    enable    = 1'b1;
    waitIdle("after reset");
    checkOutput("words_rd after reset", 32'(words_rd), 32'd4);
    checkOutput("beats left after reset", 32'(expQ.size()), 32'd0);
    doReset();

    // Beat counter saturation with a 4-bit counter.
    applyStimulus(32'h401, 20, 20, 0);
    stopReads = 17;
    m_ready   = 1'b1;
    enable    = 1'b1;
    waitIdle("saturate");
    checkOutput("words_rd saturate", 32'(words_rd), 32'd15);
    checkOutput("beats left saturate", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
